hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: register address width; 2^ADDR_W scoreboard entries.
REQ-002 SHALL have parameter LAT_W, default 4: producer latency field width; maximum latency 2^LAT_W-1.
REQ-003 SHALL have parameter NUM_SRC, default 2: source operands checked per instruction.
REQ-004 SHALL have ports in this order:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  decode-stage instruction valid.
- i_flush  in  1  squash the decode-stage instruction this cycle.
- i_src_addr  in  NUM_SRC*ADDR_W  source register addresses; source k at bits [k*ADDR_W +: ADDR_W].
- i_src_used  in  NUM_SRC  per-source read enable.
- i_dst_we  in  1  instruction writes a register.
- i_dst_addr  in  ADDR_W  destination register.
- i_dst_lat  in  LAT_W  cycles from issue until the result can be bypassed (ALU 1, load 2, mul/div N).
- o_stall  out  1  hold decode this cycle.
- o_issue  out  1  instruction leaves decode this cycle.
- o_fwd_sel  out  NUM_SRC*2  per-source operand select: 0 regfile, 1 newest-result bypass, 2 older-result bypass.
- o_busy  out  1  at least one entry pending.

Function
REQ-005 SHALL keep one entry per register: valid bit plus LAT_W-bit countdown cnt.
REQ-006 SHALL decrement every valid entry with cnt>0 on each edge, independent of stall.
REQ-007 SHALL clear a valid entry with cnt==0 on the next edge, unless it is reallocated on that edge.
REQ-008 SHALL, when o_issue & i_dst_we & i_dst_addr!=0, set that entry valid with cnt=i_dst_lat; a value of 0 SHALL be treated as 1.
REQ-009 SHALL never allocate register 0 and never report a hazard on source address 0.
REQ-010 SHALL classify each used source against the current registered state, before any same-cycle allocation: invalid -> sel 0; cnt>=2 -> hazard; cnt==1 -> sel 1; cnt==0 -> sel 2.
REQ-011 SHALL raise a WAW hazard when i_dst_we and the destination entry is valid with cnt > max(i_dst_lat,1).
REQ-012 SHALL drive o_stall = i_valid & (any RAW or WAW hazard), combinationally.
REQ-013 SHALL drive o_issue = i_valid & ~o_stall & ~i_flush; when i_flush is high, no allocation occurs.
REQ-014 SHALL drive o_fwd_sel to 0 for unused sources and whenever i_valid is 0.
REQ-015 SHALL, when reallocation and cnt==0 expiry hit the same entry on the same edge, apply the new allocation.
REQ-016 SHALL drive o_busy = OR of all entry valid bits.
REQ-017 SHALL make all outputs combinational functions of registered state and current inputs; there SHALL be no output registers.

Reset
REQ-018 SHALL, when reset_n==0 at an edge, clear all valid bits and all cnt fields, and ignore any same-cycle issue.
REQ-019 SHALL hold o_stall=0, o_busy=0, o_fwd_sel=0 and o_issue=i_valid&~i_flush during the cycle after reset.
REQ-020 SHALL, on reset asserted mid-operation, discard all pending entries with no stall carried over.

Configuration
REQ-021 SHALL compile bypass support in when macro HAZARD_SCOREBOARD_BYPASS_EN is defined: REQ-010 applies as written.
REQ-022 SHALL, without HAZARD_SCOREBOARD_BYPASS_EN, treat every valid source entry as a hazard regardless of cnt, tie o_fwd_sel to 0, and omit the bypass-select logic.

Verification
REQ-023 SHALL cover ALU back-to-back: issue add r3 (lat 1), next cycle add r4,r3,r5 -> o_stall=0, src0 sel=1; the cycle after, a reader of r3 -> sel=2; two cycles later -> sel=0 and o_busy=0.
REQ-024 SHALL cover load-use: lw r2 (lat 2), next cycle add r6,r2,r2 -> o_stall=1 for 1 cycle, then both sources sel=1 with o_issue=1.
REQ-025 SHALL cover long latency with WAW: div writes r8 (lat 6); add r8 (lat 1) one cycle later -> stall until the div entry cnt<=1; the r8 entry then holds cnt=1.
REQ-026 SHALL cover zero register and flush: dst r0 -> no allocation and o_busy stays 0; i_flush with a hazard-free instruction -> o_issue=0 and no entry set.
REQ-027 SHALL cover mid-operation reset: reset_n=0 for 1 cycle while r9 is pending at cnt=3 -> next cycle a reader of r9 gets o_stall=0, sel=0.
REQ-028 SHALL cover bypass compiled out: without the macro, lat-1 producer of r3 then a reader of r3 -> o_stall=1 for 2 cycles, sel always 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register-level RAW/WAW hazard scoreboard for an in-order decode stage.
//   One entry per architectural register holds a valid bit and a countdown of
//   the cycles left until the producing instruction's result can be bypassed.
//   Register 0 is hard-wired and is never tracked.
//
//   Optional feature macro: HAZARD_SCOREBOARD_BYPASS_EN
//     defined   : sources whose producer is one cycle away (cnt==1) or ready
//                 (cnt==0) are forwarded instead of stalling.
//     undefined : any pending producer stalls the reader; o_fwd_sel is tied 0.
//
// Parameters
//   ADDR_W  : register address width (2**ADDR_W entries)
//   LAT_W   : latency/countdown field width
//   NUM_SRC : source operands checked per instruction
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   synchronous active-low reset
//   i_valid     in   decode-stage instruction valid
//   i_flush     in   squash the decode-stage instruction
//   i_src_addr  in   packed source addresses, source k at [k*ADDR_W +: ADDR_W]
//   i_src_used  in   per-source read enable
//   i_dst_we    in   instruction writes a destination register
//   i_dst_addr  in   destination register
//   i_dst_lat   in   issue-to-bypass latency (0 treated as 1)
//   o_stall     out  hold decode this cycle
//   o_issue     out  instruction leaves decode this cycle
//   o_fwd_sel   out  per-source select: 0 regfile, 1 newest bypass, 2 older bypass
//   o_busy      out  at least one entry pending
module hazard_scoreboard #(
   parameter int ADDR_W  = 5,
   parameter int LAT_W   = 4,
   parameter int NUM_SRC = 2
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        i_valid,
   input  logic                        i_flush,
   input  logic [NUM_SRC*ADDR_W-1:0]   i_src_addr,
   input  logic [NUM_SRC-1:0]          i_src_used,
   input  logic                        i_dst_we,
   input  logic [ADDR_W-1:0]           i_dst_addr,
   input  logic [LAT_W-1:0]            i_dst_lat,
   output logic                        o_stall,
   output logic                        o_issue,
   output logic [NUM_SRC*2-1:0]        o_fwd_sel,
   output logic                        o_busy
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic [NUM_REGS-1:0] ent_valid;
   logic [LAT_W-1:0]    ent_cnt [NUM_REGS];

   logic [LAT_W-1:0]    eff_lat;
   logic                raw_hazard;
   logic                waw_hazard;
   logic                alloc;
   logic [ADDR_W-1:0]   src;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
   logic [NUM_SRC*2-1:0] fwd_sel;
`endif

   // A zero latency would allocate an entry that is already "ready"; it is
   // promoted to 1 so the producer is visible for at least one cycle.
   assign eff_lat = (i_dst_lat == '0) ? LAT_W'(1) : i_dst_lat;

   // Classification uses only the registered state, so a same-cycle
   // allocation never affects the instruction that performs it.
   always_comb begin
      raw_hazard = 1'b0;
      src        = '0;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
      fwd_sel    = '0;
`endif
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         src = i_src_addr[k*ADDR_W +: ADDR_W];
         if (i_src_used[k] && (src != '0) && ent_valid[src]) begin
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
            if (ent_cnt[src] > LAT_W'(1)) begin
               raw_hazard = 1'b1;
            end else if (ent_cnt[src] == LAT_W'(1)) begin
               fwd_sel[k*2 +: 2] = 2'd1;
            end else begin
               fwd_sel[k*2 +: 2] = 2'd2;
            end
`else
            raw_hazard = 1'b1;
`endif
         end
      end
   end

   // WAW: the new write must not complete before an older pending write.
   assign waw_hazard = i_dst_we && (i_dst_addr != '0) && ent_valid[i_dst_addr]
                       && (ent_cnt[i_dst_addr] > eff_lat);

   assign o_stall = i_valid && (raw_hazard || waw_hazard);
   assign o_issue = i_valid && !o_stall && !i_flush;
   assign o_busy  = |ent_valid;
   assign alloc   = o_issue && i_dst_we && (i_dst_addr != '0);

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
   assign o_fwd_sel = i_valid ? fwd_sel : '0;
`else
   assign o_fwd_sel = '0;
`endif

   // Countdown runs regardless of stall; allocation wins over expiry.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ent_valid <= '0;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            ent_cnt[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (alloc && (i_dst_addr == ADDR_W'(r))) begin
               ent_valid[r] <= 1'b1;
               ent_cnt[r]   <= eff_lat;
            end else if (ent_valid[r]) begin
               if (ent_cnt[r] != '0) begin
                  ent_cnt[r] <= ent_cnt[r] - LAT_W'(1);
               end else begin
                  ent_valid[r] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed scenarios plus randomized traffic for hazard_scoreboard, checked
//   against a timestamp model: each register remembers the cycle at which
//   its pending result becomes ready; remaining distance to that cycle gives
//   the hazard/bypass classification.
module tb_hazard_scoreboard;

   localparam int ADDR_W  = 5;
   localparam int LAT_W   = 4;
   localparam int NUM_SRC = 2;
   localparam int NREG    = 1 << ADDR_W;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                      clock = 1'b0;
   logic                      reset_n;
   logic                      i_valid;
   logic                      i_flush;
   logic [NUM_SRC*ADDR_W-1:0] i_src_addr;
   logic [NUM_SRC-1:0]        i_src_used;
   logic                      i_dst_we;
   logic [ADDR_W-1:0]         i_dst_addr;
   logic [LAT_W-1:0]          i_dst_lat;
   logic                      o_stall;
   logic                      o_issue;
   logic [NUM_SRC*2-1:0]      o_fwd_sel;
   logic                      o_busy;

   always #5 clock = ~clock;

   hazard_scoreboard #(
      .ADDR_W  (ADDR_W),
      .LAT_W   (LAT_W),
      .NUM_SRC (NUM_SRC)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_valid    (i_valid),
      .i_flush    (i_flush),
      .i_src_addr (i_src_addr),
      .i_src_used (i_src_used),
      .i_dst_we   (i_dst_we),
      .i_dst_addr (i_dst_addr),
      .i_dst_lat  (i_dst_lat),
      .o_stall    (o_stall),
      .o_issue    (o_issue),
      .o_fwd_sel  (o_fwd_sel),
      .o_busy     (o_busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int ready_at [NREG];   // cycle at which the pending result is ready; < cyc means idle

   logic       obs_stall;
   logic       obs_issue;
   logic [3:0] obs_fwd;
   logic       obs_busy;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One decode cycle: drive, check against the model, then advance the model.
   task automatic step(input bit rst_n, input bit v, input bit fl,
                       input int s0, input int s1, input bit [1:0] used,
                       input bit we, input int dst, input int lat);
      int  srcs [2];
      int  sel  [2];
      int  d;
      int  eff;
      bit  haz;
      bit  e_stall;
      bit  e_issue;
      bit  e_busy;
      @(negedge clock);
      reset_n    = rst_n;
      i_valid    = v;
      i_flush    = fl;
      i_src_addr = {ADDR_W'(s1), ADDR_W'(s0)};
      i_src_used = used;
      i_dst_we   = we;
      i_dst_addr = ADDR_W'(dst);
      i_dst_lat  = LAT_W'(lat);
      #1;
      srcs[0] = s0;
      srcs[1] = s1;
      eff = (lat == 0) ? 1 : lat;
      haz = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sel[k] = 0;
         if (used[k] && srcs[k] != 0 && ready_at[srcs[k]] >= cyc) begin
            d = ready_at[srcs[k]] - cyc;
            if (!BYPASS || d >= 2) haz = 1'b1;
            else if (d == 1)        sel[k] = 1;
            else                    sel[k] = 2;
         end
         if (!v) sel[k] = 0;
      end
      if (we && dst != 0 && ready_at[dst] >= cyc && (ready_at[dst] - cyc) > eff)
         haz = 1'b1;
      e_stall = v && haz;
      e_issue = v && !e_stall && !fl;
      e_busy  = 1'b0;
      for (int r = 1; r < NREG; r++)
         if (ready_at[r] >= cyc) e_busy = 1'b1;

      obs_stall = o_stall;
      obs_issue = o_issue;
      obs_fwd   = o_fwd_sel;
      obs_busy  = o_busy;
      check_eq("stall", 32'(o_stall), 32'(e_stall));
      check_eq("issue", 32'(o_issue), 32'(e_issue));
      check_eq("fwd_sel", 32'(o_fwd_sel), 32'({sel[1][1:0], sel[0][1:0]}));
      check_eq("busy", 32'(o_busy), 32'(e_busy));

      @(posedge clock);
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) ready_at[r] = -1;
      end else if (e_issue && we && dst != 0) begin
         ready_at[dst] = cyc + 1 + eff;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
   endtask

   initial begin
      int stalls;
      for (int r = 0; r < NREG; r++) ready_at[r] = -1;
      reset_n    = 1'b0;
      i_valid    = 1'b0;
      i_flush    = 1'b0;
      i_src_addr = '0;
      i_src_used = '0;
      i_dst_we   = 1'b0;
      i_dst_addr = '0;
      i_dst_lat  = '0;
      repeat (2) @(posedge clock);

      // Cycle right after reset: an issuing instruction with reset still low.
      step(0, 1, 0, 3, 4, 2'b11, 1, 7, 2);
      check_eq("rst_issue", 32'(obs_issue), 32'd1);
      check_eq("rst_busy", 32'(obs_busy), 32'd0);
      step(1, 1, 0, 7, 0, 2'b01, 0, 0, 0);   // reset-time issue must be ignored
      check_eq("rst_no_alloc", 32'(obs_stall), 32'd0);

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
      // ALU back-to-back on r3
      step(1, 1, 0, 1, 2, 2'b11, 1, 3, 1);
      step(1, 1, 0, 3, 5, 2'b11, 1, 4, 1);
      check_eq("b2b_stall", 32'(obs_stall), 32'd0);
      check_eq("b2b_sel_new", 32'(obs_fwd[1:0]), 32'd1);
      step(1, 1, 0, 3, 0, 2'b01, 0, 0, 0);
      check_eq("b2b_sel_old", 32'(obs_fwd[1:0]), 32'd2);
      idle(1);
      step(1, 1, 0, 3, 0, 2'b01, 0, 0, 0);
      check_eq("b2b_sel_rf", 32'(obs_fwd[1:0]), 32'd0);
      check_eq("b2b_busy", 32'(obs_busy), 32'd0);
      idle(2);

      // Load-use on r2
      step(1, 1, 0, 0, 0, 2'b00, 1, 2, 2);
      step(1, 1, 0, 2, 2, 2'b11, 1, 6, 1);
      check_eq("ld_use_stall", 32'(obs_stall), 32'd1);
      step(1, 1, 0, 2, 2, 2'b11, 1, 6, 1);
      check_eq("ld_use_go", 32'(obs_stall), 32'd0);
      check_eq("ld_use_issue", 32'(obs_issue), 32'd1);
      check_eq("ld_use_sel", 32'(obs_fwd), 32'h5);
      idle(4);
`else
      // No bypass: lat-1 producer of r3 stalls its reader for two cycles
      step(1, 1, 0, 0, 0, 2'b00, 1, 3, 1);
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, 3, 0, 2'b01, 0, 0, 0);
         check_eq("nobyp_sel", 32'(obs_fwd), 32'd0);
         if (!obs_stall) break;
         stalls++;
      end
      check_eq("nobyp_stalls", 32'(stalls), 32'd2);
      idle(2);
`endif

      // Long latency div then WAW on r8
      step(1, 1, 0, 0, 0, 2'b00, 1, 8, 6);
      stalls = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0, 0, 0, 2'b00, 1, 8, 1);
         if (!obs_stall) break;
         stalls++;
      end
      check_eq("waw_stalls", 32'(stalls), 32'd5);
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      check_eq("waw_cnt1_busy", 32'(obs_busy), 32'd1);
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      check_eq("waw_cnt0_busy", 32'(obs_busy), 32'd1);
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      check_eq("waw_drained", 32'(obs_busy), 32'd0);

      // Zero register and flush
      step(1, 1, 0, 0, 0, 2'b11, 1, 0, 3);
      check_eq("r0_issue", 32'(obs_issue), 32'd1);
      step(1, 1, 0, 0, 0, 2'b11, 0, 0, 0);
      check_eq("r0_busy", 32'(obs_busy), 32'd0);
      check_eq("r0_no_stall", 32'(obs_stall), 32'd0);
      step(1, 1, 1, 1, 2, 2'b11, 1, 5, 2);
      check_eq("flush_issue", 32'(obs_issue), 32'd0);
      step(1, 1, 0, 5, 0, 2'b01, 0, 0, 0);
      check_eq("flush_busy", 32'(obs_busy), 32'd0);
      check_eq("flush_no_stall", 32'(obs_stall), 32'd0);

      // Mid-operation reset while r9 pending at cnt=3
      step(1, 1, 0, 0, 0, 2'b00, 1, 9, 5);
      idle(2);
      step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      step(1, 1, 0, 9, 0, 2'b01, 0, 0, 0);
      check_eq("mid_rst_stall", 32'(obs_stall), 32'd0);
      check_eq("mid_rst_sel", 32'(obs_fwd), 32'd0);
      check_eq("mid_rst_busy", 32'(obs_busy), 32'd0);

      // Randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
